// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned AWIDTH_DEF    = 32;
  localparam int unsigned DWIDTH_DEF    = 32;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
  localparam int unsigned INSN_BYTES    = 4;

  // One buffered instruction: the fetch address and the returned word.
  typedef struct packed {
    logic [AWIDTH_DEF-1:0] pc;
    logic [DWIDTH_DEF-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched instructions; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  entry_t                 i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output entry_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Flush wins over both push and pop; pop only when something is held.
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads, buffers
// returned words with their PCs and hands them to decode. A redirect flushes
// buffered and in-flight instructions.
// Optional: define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       AWIDTH    = AWIDTH_DEF,
  parameter int unsigned       DWIDTH    = DWIDTH_DEF,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(BASE_ADDR_DEF),
  parameter int unsigned       DEPTH     = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              req_valid,
  output logic [AWIDTH-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DWIDTH-1:0] rsp_data,
  output logic              insn_valid,
  output logic [DWIDTH-1:0] insn,
  output logic [AWIDTH-1:0] insn_pc,
  input  logic              insn_ready,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned       CW   = $clog2(DEPTH) + 1;
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(INSN_BYTES);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_rsp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;

  logic [CW-1:0]     w_count;
  entry_t            w_head;
  entry_t            w_push_entry;
  logic              w_cap_ok;
  logic              w_accept;
  logic              w_rsp_ok;
  logic              w_keep;
  logic              w_pop;
  logic [AWIDTH-1:0] w_redirect_pc;
  logic [1:0]        w_unused_redirect_lsb;

  // Redirect targets are forced onto a word boundary.
  assign w_redirect_pc         = {redirect_pc[AWIDTH-1:2], 2'b00};
  assign w_unused_redirect_lsb = redirect_pc[1:0];

  // Issue only while buffered plus in-flight words leave room in the FIFO.
  assign w_cap_ok  = ((CW+1)'(w_count) + (CW+1)'(r_outstanding)) < (CW+1)'(DEPTH);
  assign req_valid = reset && !redirect_valid && w_cap_ok;
  assign req_addr  = r_pc;
  assign w_accept  = req_valid && req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok  = rsp_valid && (r_outstanding != '0);
  assign w_keep    = w_rsp_ok && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop     = insn_valid && insn_ready && !redirect_valid;

  assign w_push_entry.pc   = r_rsp_pc;
  assign w_push_entry.insn = rsp_data;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign insn_valid = (w_count != '0);
  assign insn       = w_head.insn;
  assign insn_pc    = w_head.pc;

  // Fetch PC and the PC tagged onto the next kept response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= BASE_ADDR;
      r_rsp_pc <= BASE_ADDR;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_pc;
      r_rsp_pc <= w_redirect_pc;
    end else begin
      if (w_accept) r_pc     <= r_pc + STEP;
      if (w_keep)   r_rsp_pc <= r_rsp_pc + STEP;
    end
  end

  // In-flight request count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_ok);
    end
  end

  // Stale-response counter. Responses already marked stale are a subset of
  // the outstanding ones, so at a redirect every remaining in-flight word is
  // stale, less the one (if any) returning in the redirect cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
    end else if (w_rsp_ok && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Delivered-instruction and decode-stall counters; redirect cycles excluded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (insn_valid && !insn_ready && !redirect_valid) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  // Memory must never answer a request that was not made.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid |-> (r_outstanding != '0));

  // Buffered plus in-flight words never exceed the FIFO depth.
  a_cap: assert property (@(posedge clk) disable iff (!reset)
    ((CW+1)'(w_count) + (CW+1)'(r_outstanding)) <= (CW+1)'(DEPTH));

endmodule
